// File: rtl/fp_writeback_buffer_pkg.sv
// Shared types for the FP writeback path: fx5 payload fields and the
// buffered entry layout that writeback also consumes.
package fp_writeback_buffer_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 32;

  typedef logic [NUM_LANES-1:0]             vector_lane_mask_t;
  typedef logic [1:0]                       thread_idx_t;
  typedef logic [1:0]                       subcycle_t;
  typedef logic [NUM_LANES-1:0][LANE_W-1:0] vector_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [3:0] alu_op;
    logic [4:0] dest_reg;
    logic       dest_is_vector;
    logic       has_dest;
  } decoded_instruction_t;

  typedef struct packed {
    decoded_instruction_t instruction;
    vector_lane_mask_t    mask_value;
    thread_idx_t          thread_idx;
    subcycle_t            subcycle;
    vector_t              result;
  } fp_wb_entry_t;

  localparam int FP_WB_ENTRY_W = $bits(fp_wb_entry_t);

endpackage

// File: rtl/fp_writeback_buffer_sync_fifo.sv
// Generic synchronous FIFO with a separate occupancy counter so full and
// empty are never ambiguous; storage itself is left unreset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

  // A pop frees a slot in the same cycle, so push-while-full is accepted then
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata      = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = reset ? '0 : count_d;

endmodule

// File: rtl/fp_writeback_buffer.sv
// In-order result buffer between fx5 and writeback, with an early issue
// stall so every in-flight FP instruction is guaranteed a slot.
module fp_writeback_buffer
  import fp_writeback_buffer_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter int STALL_THRESHOLD = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fx5_instruction_valid,
  input  decoded_instruction_t       fx5_instruction,
  input  vector_lane_mask_t          fx5_mask_value,
  input  thread_idx_t                fx5_thread_idx,
  input  subcycle_t                  fx5_subcycle,
  input  vector_t                    fx5_result,
  input  logic                       wb_fp_grant,
  output logic                       fpb_instruction_valid,
  output decoded_instruction_t       fpb_instruction,
  output vector_lane_mask_t          fpb_mask_value,
  output thread_idx_t                fpb_thread_idx,
  output subcycle_t                  fpb_subcycle,
  output vector_t                    fpb_result,
  output logic                       fpb_stall_issue,
  output logic [$clog2(DEPTH):0]     fpb_occupancy,
  output logic                       fpb_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  fp_wb_entry_t wr_entry;
  fp_wb_entry_t rd_entry;
  fp_wb_entry_t head;
  logic [CW-1:0] count, count_next;
  logic          full, empty;
  logic          stall_q, stall_d;
  logic          overflow_q, overflow_d;

  assign wr_entry = '{
    instruction: fx5_instruction,
    mask_value:  fx5_mask_value,
    thread_idx:  fx5_thread_idx,
    subcycle:    fx5_subcycle,
    result:      fx5_result
  };

  sync_fifo #(
    .WIDTH (FP_WB_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fx5_instruction_valid),
    .pop        (wb_fp_grant),
    .wdata      (wr_entry),
    .rdata      (rd_entry),
    .count      (count),
    .count_next (count_next),
    .full       (full),
    .empty      (empty)
  );

  always_comb begin
    stall_d    = (int'(count_next) >= DEPTH - STALL_THRESHOLD);
    // Full implies non-empty, so a grant here always frees a slot
    overflow_d = overflow_q ||
                 (fx5_instruction_valid && full && !wb_fp_grant);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

  assign head = empty ? '0 : rd_entry;

  assign fpb_instruction_valid = !empty;
  assign fpb_instruction       = head.instruction;
  assign fpb_mask_value        = head.mask_value;
  assign fpb_thread_idx        = head.thread_idx;
  assign fpb_subcycle          = head.subcycle;
  assign fpb_result            = head.result;
  assign fpb_stall_issue       = stall_q;
  assign fpb_occupancy         = count;
  assign fpb_overflow          = overflow_q;

endmodule

// File: tb/tb_fp_writeback_buffer.sv
// Bench for fp_writeback_buffer: queue-based reference model compared
// every cycle, plus literal expectations for the directed scenarios.
module tb_fp_writeback_buffer;
  import fp_writeback_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int THR   = 6;

  logic                 clk;
  logic                 reset;
  logic                 fx5_instruction_valid;
  decoded_instruction_t fx5_instruction;
  vector_lane_mask_t    fx5_mask_value;
  thread_idx_t          fx5_thread_idx;
  subcycle_t            fx5_subcycle;
  vector_t              fx5_result;
  logic                 wb_fp_grant;
  logic                 fpb_instruction_valid;
  decoded_instruction_t fpb_instruction;
  vector_lane_mask_t    fpb_mask_value;
  thread_idx_t          fpb_thread_idx;
  subcycle_t            fpb_subcycle;
  vector_t              fpb_result;
  logic                 fpb_stall_issue;
  logic [3:0]           fpb_occupancy;
  logic                 fpb_overflow;

  fp_writeback_buffer #(
    .DEPTH           (DEPTH),
    .STALL_THRESHOLD (THR)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .fx5_instruction_valid (fx5_instruction_valid),
    .fx5_instruction       (fx5_instruction),
    .fx5_mask_value        (fx5_mask_value),
    .fx5_thread_idx        (fx5_thread_idx),
    .fx5_subcycle          (fx5_subcycle),
    .fx5_result            (fx5_result),
    .wb_fp_grant           (wb_fp_grant),
    .fpb_instruction_valid (fpb_instruction_valid),
    .fpb_instruction       (fpb_instruction),
    .fpb_mask_value        (fpb_mask_value),
    .fpb_thread_idx        (fpb_thread_idx),
    .fpb_subcycle          (fpb_subcycle),
    .fpb_result            (fpb_result),
    .fpb_stall_issue       (fpb_stall_issue),
    .fpb_occupancy         (fpb_occupancy),
    .fpb_overflow          (fpb_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fp_wb_entry_t q[$];
  bit           m_ovf;
  bit           m_stall;
  bit           chk_en;
  int           tests;
  int           fails;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic fp_wb_entry_t rand_entry();
    fp_wb_entry_t e;
    logic [31:0]  r;
    e = '0;
    r = $urandom;
    e.instruction = r[$bits(decoded_instruction_t)-1:0];
    r = $urandom;
    e.mask_value = r[NUM_LANES-1:0];
    e.thread_idx = r[5:4];
    e.subcycle   = r[7:6];
    for (int l = 0; l < NUM_LANES; l++) e.result[l] = $urandom;
    return e;
  endfunction

  task automatic compare();
    fp_wb_entry_t h;
    h = (q.size() > 0) ? q[0] : '0;
    chk("valid", 256'(fpb_instruction_valid), 256'(q.size() > 0));
    chk("instr", 256'(fpb_instruction), 256'(h.instruction));
    chk("mask", 256'(fpb_mask_value), 256'(h.mask_value));
    chk("thread", 256'(fpb_thread_idx), 256'(h.thread_idx));
    chk("subcycle", 256'(fpb_subcycle), 256'(h.subcycle));
    chk("result", 256'(fpb_result), 256'(h.result));
    chk("occupancy", 256'(fpb_occupancy), 256'(q.size()));
    chk("stall", 256'(fpb_stall_issue), 256'(m_stall));
    chk("overflow", 256'(fpb_overflow), 256'(m_ovf));
  endtask

  // One clock: check current outputs, drive inputs, advance the model.
  task automatic cyc(input bit v, input fp_wb_entry_t e,
                     input bit g, input bit r);
    if (chk_en) compare();
    reset                 = r;
    fx5_instruction_valid = v;
    fx5_instruction       = e.instruction;
    fx5_mask_value        = e.mask_value;
    fx5_thread_idx        = e.thread_idx;
    fx5_subcycle          = e.subcycle;
    fx5_result            = e.result;
    wb_fp_grant           = g;
    if (r) begin
      q.delete();
      m_ovf   = 1'b0;
      m_stall = 1'b0;
    end else begin
      if (g && q.size() > 0) void'(q.pop_front());
      if (v) begin
        if (q.size() < DEPTH) q.push_back(e);
        else m_ovf = 1'b1;
      end
      m_stall = (q.size() >= DEPTH - THR);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i <= DEPTH && q.size() > 0; i++) cyc(0, '0, 1, 0);
  endtask

  initial begin
    fp_wb_entry_t e;
    bit v, g;
    tests  = 0;
    fails  = 0;
    chk_en = 1'b0;
    m_ovf  = 1'b0;
    m_stall = 1'b0;
    reset  = 1'b1;
    fx5_instruction_valid = 1'b0;
    fx5_instruction = '0;
    fx5_mask_value  = '0;
    fx5_thread_idx  = '0;
    fx5_subcycle    = '0;
    fx5_result      = '0;
    wb_fp_grant     = 1'b0;
    @(negedge clk);
    cyc(0, '0, 0, 1);
    cyc(0, '0, 0, 1);
    chk_en = 1'b1;

    chk("rst_valid", 256'(fpb_instruction_valid), 256'(0));
    chk("rst_occ", 256'(fpb_occupancy), 256'(0));
    chk("rst_stall", 256'(fpb_stall_issue), 256'(0));
    chk("rst_ovf", 256'(fpb_overflow), 256'(0));
    chk("rst_result", 256'(fpb_result), 256'(0));

    // single pass-through with grant held high
    e = rand_entry();
    e.result[0]  = 32'h3f800000;
    e.thread_idx = 2'd2;
    cyc(1, e, 1, 0);
    chk("pt_valid", 256'(fpb_instruction_valid), 256'(1));
    chk("pt_lane0", 256'(fpb_result[0]), 256'(32'h3f800000));
    chk("pt_thread", 256'(fpb_thread_idx), 256'(2));
    chk("pt_occ1", 256'(fpb_occupancy), 256'(1));
    cyc(0, '0, 1, 0);
    chk("pt_occ0", 256'(fpb_occupancy), 256'(0));

    // fill with results 1..8
    for (int i = 1; i <= DEPTH; i++) begin
      e = rand_entry();
      e.result[0] = 32'(i);
      cyc(1, e, 0, 0);
      if (i == 1) chk("stall_at1", 256'(fpb_stall_issue), 256'(0));
      if (i == 2) chk("stall_at2", 256'(fpb_stall_issue), 256'(1));
    end
    chk("fill_occ", 256'(fpb_occupancy), 256'(8));
    chk("fill_head", 256'(fpb_result[0]), 256'(1));

    // push 9 while popping at full
    e = rand_entry();
    e.result[0] = 32'd9;
    cyc(1, e, 1, 0);
    chk("fullpp_occ", 256'(fpb_occupancy), 256'(8));
    chk("fullpp_ovf", 256'(fpb_overflow), 256'(0));
    for (int k = 2; k <= 9; k++) begin
      chk("drain_seq", 256'(fpb_result[0]), 256'(k));
      cyc(0, '0, 1, 0);
    end
    chk("drain_valid", 256'(fpb_instruction_valid), 256'(0));
    chk("drain_zero", 256'(fpb_result), 256'(0));
    chk("drain_stall", 256'(fpb_stall_issue), 256'(0));

    // overflow: full, no grant, one extra push
    for (int i = 1; i <= DEPTH; i++) begin
      e = rand_entry();
      e.result[0] = 32'(16 + i);
      cyc(1, e, 0, 0);
    end
    e = rand_entry();
    e.result[0] = 32'hdead;
    cyc(1, e, 0, 0);
    chk("ovf_set", 256'(fpb_overflow), 256'(1));
    chk("ovf_occ", 256'(fpb_occupancy), 256'(8));
    for (int k = 17; k <= 24; k++) begin
      chk("ovf_seq", 256'(fpb_result[0]), 256'(k));
      cyc(0, '0, 1, 0);
    end
    chk("ovf_empty", 256'(fpb_instruction_valid), 256'(0));
    chk("ovf_sticky", 256'(fpb_overflow), 256'(1));
    cyc(0, '0, 0, 1);
    chk("ovf_clear", 256'(fpb_overflow), 256'(0));

    // random traffic, occupancy never exceeds DEPTH
    for (int n = 0; n < 300; n++) begin
      g = ($urandom_range(0, 2) != 0);
      v = ($urandom_range(0, 3) != 0) &&
          (q.size() < DEPTH || (g && q.size() > 0));
      cyc(v, rand_entry(), g, 0);
    end
    chk("rand_ovf", 256'(fpb_overflow), 256'(0));

    // reset mid-operation with push and grant presented
    drain();
    for (int i = 0; i < 5; i++) cyc(1, rand_entry(), 0, 0);
    chk("pre_rst_occ", 256'(fpb_occupancy), 256'(5));
    cyc(1, rand_entry(), 1, 1);
    chk("mid_rst_valid", 256'(fpb_instruction_valid), 256'(0));
    chk("mid_rst_occ", 256'(fpb_occupancy), 256'(0));
    chk("mid_rst_stall", 256'(fpb_stall_issue), 256'(0));
    chk("mid_rst_ovf", 256'(fpb_overflow), 256'(0));
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
